rr_arbiter_4: RTL and testbench
===============================

Name: rr_arbiter_4

Overview:
Four-requester round-robin arbiter that shares one resource between requesters 0-3. It holds a grant while the owner keeps its request high, and revokes it after MAX_HOLD cycles if another requester is waiting. The one-hot grant vector is produced by the team's 2-to-4 decoder from the registered owner ID. It sits between requesting blocks and the shared resource's select lines.

Parameters:
MAX_HOLD, 8, maximum consecutive granted cycles before preemption when others wait; 0 disables preemption.
CNT_W, 4, hold counter width; must satisfy 2^CNT_W > MAX_HOLD.

Ports:
clk  input  1  rising-edge clock, single clock domain
rst_n  input  1  asynchronous active-low reset
req  input  4  level request per requester; bit i = requester i
gnt  output  4  one-hot grant; all zero when no owner
gnt_id  output  2  ID of current owner; valid only when gnt_valid=1
gnt_valid  output  1  resource currently granted
preempt  output  1  one-cycle pulse in the cycle after a timeout revocation

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, ptr=0, gnt_id=0, gnt_valid=0, gnt=0000, hold_cnt=0, preempt=0. Outputs are low immediately on assertion, independent of clk.
- gnt is computed by a decoder from registered gnt_id, ANDed with gnt_valid. There is no combinational path from req to any output.
- States: IDLE, BUSY.
- IDLE: at an edge with req!=0, select the first set bit searching ptr, ptr+1, ... mod 4.
  - gnt_id := winner, gnt_valid := 1, hold_cnt := 1, next state BUSY.
  - Latency is 1 edge: gnt is high in the cycle after req is sampled.
  - With req=0, the block stays in IDLE and all outputs stay 0.
- BUSY, evaluated in priority order at each edge:
  1. req[gnt_id]=0 (release): gnt_valid := 0, ptr := gnt_id+1 mod 4, go to IDLE.
  2. MAX_HOLD!=0, hold_cnt==MAX_HOLD, and any other req bit set: gnt_valid := 0, ptr := gnt_id+1 mod 4, preempt := 1 for one cycle, go to IDLE.
  3. Otherwise stay in BUSY; hold_cnt increments and saturates at MAX_HOLD.
- Handoff gap: every ownership change passes through IDLE, so there is exactly one cycle with gnt=0000 between owners. The resource never sees two owners in adjacent cycles.
- Same-requester regrant: if the releasing owner re-raises req and no one else requests, it is granted again after the 1-cycle gap, because the search wraps.
- Preemption with owner still requesting: the owner goes to the lowest priority and is regranted only after the others are served or drop.
- ptr wrap-around: 3+1 becomes 0.
- ptr updates only on release or preempt, never on grant.
- preempt is 0 in all cycles except the one after a revocation edge.
- Requests that rise and fall while another requester owns the resource are not remembered. The arbiter is level-sensitive only.
- Reset mid-grant: gnt drops asynchronously. After deassertion the arbiter restarts from ptr=0 in IDLE.

Decomposition:
- Shared constants file: NUM_REQ=4, ID_W=2, state encodings IDLE=1'b0, BUSY=1'b1.
- Sub-module: decoder_2to4 instantiated once; inputs gnt_id[0] and gnt_id[1], outputs ANDed with gnt_valid to form gnt[3:0].
- Priority search (rotate by ptr, then find first set bit) is a local function; no separate module.

Test Plan:
- Reset: hold rst_n=0 with req=1111 -> gnt=0000, gnt_valid=0, preempt=0. Release reset -> gnt=0001 one edge later.
- Round-robin: req=1111 held with MAX_HOLD=8 and no releases -> grants 0001, 0010, 0100, 1000, 0001. Each grant lasts 8 cycles, followed by a 1-cycle 0000 gap and a preempt pulse.
- Release and rotate: req=0101, requester 0 granted, then req[0] drops after 3 cycles -> one cycle at 0000, then gnt=0100. ptr wraps correctly when requester 3 releases.
- Lone owner: only req[2]=1 for 20 cycles -> gnt=0100 continuously, no preempt, hold_cnt saturates at 8.
- MAX_HOLD=0 with req=0011 -> requester 0 keeps gnt=0001 until it releases. preempt never asserts.
- Async reset mid-grant: assert rst_n between clock edges while gnt=0010 -> gnt=0000 immediately. After reset, req=1010 -> gnt=0010 (ptr back to 0).

Source files
------------

// File: rtl/rr_arbiter_4_pkg.sv
// ============================================================================
// Module      : rr_arbiter_4_pkg
// Description : Shared constants and types for the four-requester arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rr_arbiter_4_pkg;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    typedef logic [ID_W-1:0]    id_t;
    typedef logic [NUM_REQ-1:0] req_vec_t;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter_4_decoder_2to4.sv
// ============================================================================
// Module      : decoder_2to4
// Description : Binary 2-to-4 one-hot decoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module decoder_2to4 (
    input  logic       a0,
    input  logic       a1,
    output logic [3:0] y
);

    always_comb begin
        y = 4'b0001 << {a1, a0};
    end

endmodule

`default_nettype wire

// File: rtl/rr_arbiter_4.sv
// ============================================================================
// Module      : rr_arbiter_4
// Description : Four-requester round-robin arbiter with hold-time preemption.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter_4
    import rr_arbiter_4_pkg::*;
#(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    gnt_id,
    output logic               gnt_valid,
    output logic               preempt
);

    localparam logic [CNT_W-1:0] c_max_hold = CNT_W'(MAX_HOLD);

    logic [0:0]       r_state;
    id_t              r_ptr;
    id_t              r_gnt_id;
    logic             r_gnt_valid;
    logic [CNT_W-1:0] r_hold_cnt;
    logic             r_preempt;

    id_t              w_winner;
    req_vec_t         w_owner_mask;
    logic             w_others;
    logic             w_timeout;
    logic [3:0]       w_dec;

    // First set bit of req, searching ptr, ptr+1, ... modulo NUM_REQ.
    function automatic id_t rr_pick(input req_vec_t r, input id_t ptr);
        req_vec_t rot;
        id_t      off;
        for (int k = 0; k < NUM_REQ; k++) begin
            rot[k] = r[ID_W'(ptr + ID_W'(k))];
        end
        off = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (rot[k]) off = ID_W'(k);
        end
        return id_t'(ptr + off);
    endfunction

    always_comb begin
        w_winner     = rr_pick(req, r_ptr);
        w_owner_mask = req_vec_t'(1) << r_gnt_id;
        w_others     = |(req & ~w_owner_mask);
        w_timeout    = (MAX_HOLD != 0) && (r_hold_cnt == c_max_hold) && w_others;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_ptr       <= '0;
            r_gnt_id    <= '0;
            r_gnt_valid <= 1'b0;
            r_hold_cnt  <= '0;
            r_preempt   <= 1'b0;
        end else begin
            r_preempt <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (|req) begin
                        r_gnt_id    <= w_winner;
                        r_gnt_valid <= 1'b1;
                        r_hold_cnt  <= CNT_W'(1);
                        r_state     <= BUSY;
                    end
                end
                BUSY: begin
                    if (!req[r_gnt_id]) begin
                        r_gnt_valid <= 1'b0;
                        r_ptr       <= r_gnt_id + 2'd1;
                        r_state     <= IDLE;
                    end else if (w_timeout) begin
                        r_gnt_valid <= 1'b0;
                        r_ptr       <= r_gnt_id + 2'd1;
                        r_preempt   <= 1'b1;
                        r_state     <= IDLE;
                    end else if (r_hold_cnt < c_max_hold) begin
                        r_hold_cnt <= r_hold_cnt + CNT_W'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    decoder_2to4 u_dec (
        .a0 (r_gnt_id[0]),
        .a1 (r_gnt_id[1]),
        .y  (w_dec)
    );

    assign gnt       = w_dec & {NUM_REQ{r_gnt_valid}};
    assign gnt_id    = r_gnt_id;
    assign gnt_valid = r_gnt_valid;
    assign preempt   = r_preempt;

endmodule

`default_nettype wire

// File: tb/tb_rr_arbiter_4.sv
// ============================================================================
// Module      : tb_rr_arbiter_4
// Description : Directed self-checking bench for rr_arbiter_4.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rr_arbiter_4;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       gnt_valid;
    logic       preempt;

    logic [3:0] req0;
    logic [3:0] gnt0;
    logic [1:0] gnt_id0;
    logic       gnt_valid0;
    logic       preempt0;

    int checks   = 0;
    int failures = 0;

    rr_arbiter_4 #(.MAX_HOLD(8), .CNT_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid),
        .preempt   (preempt)
    );

    rr_arbiter_4 #(.MAX_HOLD(0), .CNT_W(4)) dut0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req0),
        .gnt       (gnt0),
        .gnt_id    (gnt_id0),
        .gnt_valid (gnt_valid0),
        .preempt   (preempt0)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    initial begin
        logic [3:0] onehot;

        rst_n = 1'b0;
        req   = 4'b1111;
        req0  = 4'b0000;
        repeat (3) step();
        chk("rst_gnt",     gnt,       4'b0000);
        chk("rst_valid",   gnt_valid, 1'b0);
        chk("rst_preempt", preempt,   1'b0);
        chk("rst_gnt0",    gnt0,      4'b0000);

        // Full contention: each owner holds 8 cycles, then gap + preempt pulse.
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            onehot = 4'b0001 << k;
            step();
            chk("rr_grant", gnt, onehot);
            chk("rr_nopre", preempt, 1'b0);
            repeat (7) begin
                step();
                chk("rr_hold", gnt, onehot);
            end
            step();
            chk("rr_gap", gnt, 4'b0000);
            chk("rr_preempt", preempt, 1'b1);
        end
        step();
        chk("rr_wrap_gnt", gnt, 4'b0001);
        chk("rr_wrap_id", gnt_id, 2'd0);
        chk("rr_wrap_nopre", preempt, 1'b0);

        req = 4'b0000;
        step();
        chk("rel_gap", gnt, 4'b0000);
        chk("rel_nopre", preempt, 1'b0);

        rst_n = 1'b0;
        step();
        rst_n = 1'b1;

        // Release and rotate.
        req = 4'b0101;
        step();
        chk("rot_g0", gnt, 4'b0001);
        step();
        step();
        chk("rot_g0_hold", gnt, 4'b0001);
        req = 4'b0100;
        step();
        chk("rot_gap", gnt, 4'b0000);
        chk("rot_gap_pre", preempt, 1'b0);
        step();
        chk("rot_g2", gnt, 4'b0100);

        req = 4'b1001;
        step();
        chk("rot_gap2", gnt, 4'b0000);
        step();
        chk("rot_g3", gnt, 4'b1000);
        chk("rot_g3_id", gnt_id, 2'd3);

        req = 4'b0011;
        step();
        chk("wrap_gap", gnt, 4'b0000);
        step();
        chk("wrap_g0", gnt, 4'b0001);

        // Same requester re-raises after releasing.
        req = 4'b0000;
        step();
        chk("regrant_gap", gnt, 4'b0000);
        req = 4'b0001;
        step();
        chk("regrant_g0", gnt, 4'b0001);

        // Lone owner: no preemption, counter saturates.
        req = 4'b0100;
        step();
        chk("lone_gap", gnt, 4'b0000);
        step();
        chk("lone_g2", gnt, 4'b0100);
        repeat (20) begin
            step();
            chk("lone_hold", gnt, 4'b0100);
            chk("lone_nopre", preempt, 1'b0);
        end
        req = 4'b0101;
        step();
        chk("lone_sat_gap", gnt, 4'b0000);
        chk("lone_sat_pre", preempt, 1'b1);
        step();
        chk("lone_next_g0", gnt, 4'b0001);
        chk("lone_next_nopre", preempt, 1'b0);

        // MAX_HOLD = 0: never preempted.
        req0 = 4'b0011;
        step();
        chk("mh0_g0", gnt0, 4'b0001);
        repeat (20) begin
            step();
            chk("mh0_hold", gnt0, 4'b0001);
            chk("mh0_nopre", preempt0, 1'b0);
        end
        req0 = 4'b0010;
        step();
        chk("mh0_gap", gnt0, 4'b0000);
        step();
        chk("mh0_g1", gnt0, 4'b0010);

        // Asynchronous reset while requester 1 owns with ptr=3.
        req = 4'b0100;
        step();
        step();
        chk("ar_g2", gnt, 4'b0100);
        req = 4'b0010;
        step();
        step();
        chk("ar_g1", gnt, 4'b0010);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_gnt_async", gnt, 4'b0000);
        chk("ar_valid_async", gnt_valid, 1'b0);
        step();
        rst_n = 1'b1;
        req = 4'b1010;
        step();
        chk("ar_post_gnt", gnt, 4'b0010);
        chk("ar_post_id", gnt_id, 2'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
